// File: rtl/serial_paralelo_rx_sync.sv
// serial_paralelo_rx_sync: bit-serial to parallel receiver that aligns on COM, tracks lock and flags IDLE symbols.
// Define SPRX_POLARITY_INV_EN to also accept an inverted COM in HUNT and expose the pol_inv output.
module serial_paralelo_rx_sync #(
    parameter int               SYM_W      = 8,
    parameter logic [SYM_W-1:0] COM_SYM    = 8'hBC,
    parameter logic [SYM_W-1:0] IDLE_SYM   = 8'h7C,
    parameter int               LOCK_COUNT = 4,
    parameter int               MAX_ERR    = 3
) (
    input  logic             clk_1,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    output logic [SYM_W-1:0] data_out,
    output logic             data_valid,
    output logic             locked,
`ifdef SPRX_POLARITY_INV_EN
    output logic             pol_inv,
`endif
    output logic             idle_out
);
    typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;
    state_t           state, state_n;
    logic [SYM_W-1:0] sr, sr_n, w, data_out_n;
    logic [3:0]       bit_cnt, bit_cnt_n, com_cnt, com_cnt_n, err_cnt, err_cnt_n;
    logic             pol, pol_n, data_valid_n, idle_n, boundary, is_com, inv_com;

    // pol stays 0 unless the inverted-COM path is built in
    assign w        = {sr[SYM_W-2:0], serial_in ^ pol};
    assign boundary = bit_cnt == 4'(SYM_W - 1);
    assign is_com   = w == COM_SYM;
    assign locked   = state == LOCKED;
`ifdef SPRX_POLARITY_INV_EN
    assign inv_com  = state == HUNT && w == ~COM_SYM;
    assign pol_inv  = pol;
`else
    assign inv_com  = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        sr_n         = sr;
        bit_cnt_n    = bit_cnt;
        com_cnt_n    = com_cnt;
        err_cnt_n    = err_cnt;
        pol_n        = pol;
        data_out_n   = data_out;
        data_valid_n = 1'b0;
        idle_n       = 1'b0;
        if (bit_valid) begin
            sr_n      = w;
            bit_cnt_n = boundary ? 4'd0 : bit_cnt + 4'd1;
            case (state)
                HUNT: begin
                    if (is_com || inv_com) begin
                        bit_cnt_n = 4'd0;
                        com_cnt_n = 4'd1;
                        state_n   = LOCK_COUNT == 1 ? LOCKED : ALIGN;
                        sr_n      = inv_com ? COM_SYM : w;
                        pol_n     = pol | inv_com;
                    end
                end
                ALIGN: begin
                    if (is_com && boundary) begin
                        com_cnt_n = com_cnt + 4'd1;
                        state_n   = com_cnt_n == 4'(LOCK_COUNT) ? LOCKED : ALIGN;
                    end else if (is_com) begin
                        bit_cnt_n = 4'd0;
                        com_cnt_n = 4'd1;
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        data_out_n   = w;
                        data_valid_n = 1'b1;
                        idle_n       = w == IDLE_SYM;
                        err_cnt_n    = is_com ? 4'd0 : err_cnt;
                    end else if (is_com) begin
                        err_cnt_n = err_cnt + 4'd1;
                        if (err_cnt_n == 4'(MAX_ERR)) begin
                            state_n   = HUNT;
                            err_cnt_n = 4'd0;
                            com_cnt_n = 4'd0;
                            pol_n     = 1'b0;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_1) begin
        if (!reset) begin
            state      <= HUNT;
            sr         <= '0;
            bit_cnt    <= 4'd0;
            com_cnt    <= 4'd0;
            err_cnt    <= 4'd0;
            pol        <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            idle_out   <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            bit_cnt    <= bit_cnt_n;
            com_cnt    <= com_cnt_n;
            err_cnt    <= err_cnt_n;
            pol        <= pol_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            idle_out   <= idle_n;
        end
    end
endmodule

// File: tb/tb_serial_paralelo_rx_sync.sv
// tb_serial_paralelo_rx_sync: directed serial streams; expected symbols are queued and checked on each data_valid strobe.
module tb_serial_paralelo_rx_sync;
    logic       clk_1 = 1'b0, reset = 1'b0, serial_in = 1'b0, bit_valid = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, locked, idle_out;
`ifdef SPRX_POLARITY_INV_EN
    logic       pol_inv;
`endif
    int         total = 0, bad = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [7:0] com = 8'hBC, idl = 8'h7C;

    serial_paralelo_rx_sync dut (
        .clk_1(clk_1),
        .reset(reset),
        .serial_in(serial_in),
        .bit_valid(bit_valid),
        .data_out(data_out),
        .data_valid(data_valid),
        .locked(locked),
`ifdef SPRX_POLARITY_INV_EN
        .pol_inv(pol_inv),
`endif
        .idle_out(idle_out)
    );

    always #5 clk_1 = ~clk_1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk_1);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        bit_valid = 1'b1;
        tick();
    endtask

    task automatic expect_sym(input logic [7:0] s, input logic idle);
        exp_q.push_back({idle, s});
    endtask

    task automatic send_sym(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) send_bit(s[i]);
    endtask

    task automatic zeros(input int n);
        repeat (n) send_bit(1'b0);
    endtask

    // scoreboard monitor, sampled away from the active edge
    always @(negedge clk_1) begin
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: data_out=%0h with nothing expected", data_out);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data_out", data_out, e[7:0]);
                chk("sb_idle_out", idle_out, e[8]);
            end
        end else if (idle_out) begin
            total++;
            bad++;
            $display("FAIL idle_without_valid: idle_out=1 data_valid=0");
        end
    end

    initial begin
        tick();
        tick();
        reset = 1'b1;
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_idle_out", idle_out, 0);
`ifdef SPRX_POLARITY_INV_EN
        chk("rst_pol_inv", pol_inv, 0);
`endif
        // non-COM symbol while aligning does not count
        send_sym(com);
        send_sym(8'h4A);
        send_sym(com);
        send_sym(com);
        chk("align_3com_unlocked", locked, 0);
        send_sym(com);
        chk("align_4com_locked", locked, 1);
        expect_sym(8'h7C, 1'b1);
        send_sym(idl);
        chk("align_data_out", data_out, 8'h7C);
        // reset in the middle of a symbol
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b0;
        send_bit(1'b1);
        reset = 1'b1;
        chk("midrst_locked", locked, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_data_valid", data_valid, 0);
        chk("midrst_idle_out", idle_out, 0);
        // lock acquisition after junk bits
        zeros(3);
        repeat (3) send_sym(com);
        for (int i = 7; i >= 1; i--) send_bit(com[i]);
        chk("acq_bit31_unlocked", locked, 0);
        send_bit(com[0]);
        chk("acq_bit32_locked", locked, 1);
        chk("acq_no_strobe_on_lock", data_valid, 0);
        expect_sym(8'h7C, 1'b1);
        send_sym(idl);
        chk("acq_valid", data_valid, 1);
        chk("acq_idle", idle_out, 1);
        bit_valid = 1'b0;
        tick();
        chk("acq_valid_one_cycle", data_valid, 0);
        chk("acq_idle_one_cycle", idle_out, 0);
        // bit_valid gap mid-symbol
        for (int i = 7; i >= 4; i--) send_bit(idl[i]);
        bit_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("gap_valid_low", data_valid, 0);
            chk("gap_data_hold", data_out, 8'h7C);
        end
        expect_sym(8'h7C, 1'b1);
        for (int i = 3; i >= 1; i--) send_bit(idl[i]);
        chk("gap_not_yet", data_valid, 0);
        send_bit(idl[0]);
        chk("gap_strobe", data_valid, 1);
        chk("gap_idle", idle_out, 1);
        expect_sym(8'hA5, 1'b0);
        send_sym(8'hA5);
        expect_sym(8'hBC, 1'b0);
        send_sym(com);
        // three COMs shifted by two bits drop lock
        repeat (3) expect_sym(8'h2F, 1'b0);
        zeros(2);
        send_sym(com);
        send_sym(com);
        chk("lol_held_after_2", locked, 1);
        send_sym(com);
        chk("lol_dropped", locked, 0);
        repeat (3) send_sym(com);
        chk("relock_3com_unlocked", locked, 0);
        send_sym(com);
        chk("relock_locked", locked, 1);
        // an aligned COM between misaligned ones clears the error count
        expect_sym(8'h2F, 1'b0);
        expect_sym(8'h00, 1'b0);
        expect_sym(8'hBC, 1'b0);
        expect_sym(8'h2F, 1'b0);
        expect_sym(8'h0B, 1'b0);
        expect_sym(8'hC0, 1'b0);
        expect_sym(8'h7C, 1'b1);
        zeros(2);
        send_sym(com);
        zeros(6);
        send_sym(com);
        zeros(2);
        send_sym(com);
        zeros(2);
        send_sym(com);
        chk("errclr_lock_held", locked, 1);
        zeros(4);
        send_sym(idl);
        chk("errclr_final_locked", locked, 1);
        chk("errclr_final_idle", idle_out, 1);
`ifdef SPRX_POLARITY_INV_EN
        // inverted stream: ~COM then ~IDLE
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("pol_reset", pol_inv, 0);
        repeat (4) send_sym(8'h43);
        chk("pol_inv_set", pol_inv, 1);
        chk("pol_locked", locked, 1);
        expect_sym(8'h7C, 1'b1);
        send_sym(8'h83);
        chk("pol_data_out", data_out, 8'h7C);
        chk("pol_idle", idle_out, 1);
`endif
        bit_valid = 1'b0;
        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
